mc_datapath: RTL and testbench
==============================

Name: mc_datapath

Overview:
- Multicycle 16-bit datapath. It is the execution end of the multicycle controller interface.
- Consumes the controller's strobes: IRWrite, PCWrite, RegWrite, MemWrite, ALUop and state.
- Returns the current opcode to the controller.
- Holds PC, IR, a 16x16 register file, the A/B/ALUOut/MDR holding registers and the ALU.
- Drives a unified word-addressed memory with asynchronous read.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- R0_ZERO, 1, when 1, R0 reads 0 and writes to it are dropped.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- state  in  3  controller state: 0 fetch, 1 decode, 2 execute, 3 memory, 4 writeback
- IRWrite  in  1  load IR from mem_rdata
- PCWrite  in  1  PC <= PC+1
- RegWrite  in  1  write register file at rd
- MemWrite  in  1  memory write request
- ALUop  in  4  ALU operation select
- opcode  out  4  IR[15:12], to controller
- mem_addr  out  16  memory word address
- mem_wdata  out  16  store data
- mem_we  out  1  memory write enable
- mem_rdata  in  16  read data, valid combinationally for mem_addr
- pc  out  16  current PC
- zero  out  1  ALUOut == 0
- dbg_addr  in  4  debug register-file read address
- dbg_data  out  16  R[dbg_addr], combinational, R0_ZERO rule applies

Behaviour:
- Clock and reset (already decided): reset reset, asynchronous, active-high; clock clk.
- On reset:
  - pc = PC_RESET.
  - IR, A, B, ALUOut, MDR and all 16 registers = 0.
  - Therefore opcode = 0, zero = 1, mem_we = 0.
- Instruction format:
  - [15:12] opcode, [11:8] rd, [7:4] rs, [3:0] rt/imm4.
  - imm8 = [7:0].
- ALU ops, all arithmetic mod 2^16:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT: signed, result 1/0.
  - 0110 LW and 0111 SW: address = A + zext(imm4).
  - 1000 SHL: A << B[3:0]. 1001 SHR: logical, A >> B[3:0].
  - 1010 LI: result = zext(imm8).
  - 1011–1111: result = A.
- Register-file reads:
  - Port A reads rs.
  - Port B reads rd when opcode == 0111, otherwise rt.
- State 0, fetch:
  - mem_addr = pc.
  - IRWrite: IR <= mem_rdata.
  - PCWrite: pc <= pc+1, same edge. IR captures data at the old pc.
  - pc wraps FFFF -> 0000.
- State 1, decode: A <= R[rs]; B <= R[B-port address].
- State 2, execute: ALUOut <= ALU(ALUop, A, B or immediate).
  - Immediate is used for LW/SW (imm4) and LI (imm8).
  - ALUop is used as given; the datapath does not re-decode opcode for ALU function.
- State 3, memory:
  - mem_addr = ALUOut; mem_wdata = B.
  - mem_we = MemWrite && state == 3. Strictly combinational, no register; drops immediately on reset.
  - MDR <= mem_rdata every state-3 cycle.
- State 4, writeback:
  - RegWrite: R[rd] <= (opcode == 0110) ? MDR : ALUOut.
  - Write to R0 is discarded when R0_ZERO = 1.
- mem_addr in states 1, 2 and 4 = ALUOut. Memory must not be written in those states.
- Strobes arriving in a state that does not own them (e.g. RegWrite in state 2) are still honoured as defined above. The controller owns sequencing.
- Latency:
  - Non-memory instructions take 4 cycles (0, 1, 2, 4).
  - LW/SW take 5 cycles.
  - A register written at writeback is readable at the next instruction's decode.
- Reset asserted mid-instruction aborts it:
  - No register write after reset.
  - Memory write suppressed from the reset assertion onward.
- States 5–7: no register updates; mem_addr = ALUOut; mem_we = 0.

Test Plan:
1. Reset release -> pc = 0000, opcode = 0, mem_we = 0, zero = 1, dbg_data = 0 for all 16 addresses.
2. Memory holds LI R1,0x12; LI R2,0x34; ADD R3,R1,R2. Driven by the controller for 12 cycles -> R3 = 0x0046, pc = 0003.
3. SW R3,[R0+5] -> exactly one cycle of mem_we = 1 with mem_addr = 0005, mem_wdata = 0x0046. Then LW R4,[R0+5] -> R4 = 0x0046 after 5 cycles.
4. R1 = 0, R2 = 1, SUB R5,R1,R2 -> R5 = 0xFFFF, zero = 0. SUB R6,R2,R2 -> R6 = 0, zero = 1 after execute. SLT R7,R5,R1 -> R7 = 1.
5. LI R0,0xFF -> dbg R0 = 0000. SHL R8,R2,R9 with R9 = 0x0013 -> R8 = 0x0008 (shift by 3).
6. Assert reset during state 3 of an SW -> mem_we falls in the same cycle, memory is unchanged, and pc/IR/registers return to reset values.

Source files
------------

// File: rtl/mc_datapath.sv
// Multicycle 16-bit datapath: PC, IR, 16x16 register file, A/B/ALUOut/MDR holding
// registers and ALU, sequenced by an external controller through per-state strobes.
module mc_datapath #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter bit          R0_ZERO  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  state,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic        RegWrite,
  input  logic        MemWrite,
  input  logic [3:0]  ALUop,
  output logic [3:0]  opcode,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [15:0] pc,
  output logic        zero,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  localparam int unsigned W    = 16;
  localparam int unsigned NREG = 16;
  localparam int unsigned RA_W = 4;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_SLT = 4'h5;
  localparam logic [3:0] OP_LW  = 4'h6;
  localparam logic [3:0] OP_SW  = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_LI  = 4'hA;

  logic [W-1:0]    pc_q, pc_d;
  logic [W-1:0]    ir_q, ir_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    alu_q, alu_d;
  logic [W-1:0]    mdr_q, mdr_d;
  logic [W-1:0]    rf_q [NREG];

  logic [RA_W-1:0] f_rd, f_rs, f_rt, b_addr;
  logic [7:0]      f_imm8;
  logic [W-1:0]    rd_a, rd_b, wb_data;
  logic [W-1:0]    alu_opb, alu_res;
  logic            slt_lt;
  logic            state_ok;
  logic            rf_we;

  // Instruction fields
  assign opcode = ir_q[15:12];
  assign f_rd   = ir_q[11:8];
  assign f_rs   = ir_q[7:4];
  assign f_rt   = ir_q[3:0];
  assign f_imm8 = ir_q[7:0];

  // Stores read their data register through the B port, addressed by rd
  assign b_addr = (opcode == OP_SW) ? f_rd : f_rt;

  assign rd_a     = (R0_ZERO && f_rs == '0)     ? '0 : rf_q[f_rs];
  assign rd_b     = (R0_ZERO && b_addr == '0)   ? '0 : rf_q[b_addr];
  assign dbg_data = (R0_ZERO && dbg_addr == '0) ? '0 : rf_q[dbg_addr];

  assign wb_data  = (opcode == OP_LW) ? mdr_q : alu_q;
  assign state_ok = (state <= ST_WB);

  // ALU: second operand is an immediate for LW/SW/LI, else B
  always_comb begin
    alu_opb = b_q;
    unique case (ALUop)
      OP_LW, OP_SW: alu_opb = {{(W-4){1'b0}}, f_rt};
      OP_LI:        alu_opb = {{(W-8){1'b0}}, f_imm8};
      default:      alu_opb = b_q;
    endcase
  end

  assign slt_lt = ($signed(a_q) < $signed(alu_opb));

  always_comb begin
    alu_res = a_q;
    unique case (ALUop)
      OP_ADD:       alu_res = a_q + alu_opb;
      OP_SUB:       alu_res = a_q - alu_opb;
      OP_AND:       alu_res = a_q & alu_opb;
      OP_OR:        alu_res = a_q | alu_opb;
      OP_XOR:       alu_res = a_q ^ alu_opb;
      OP_SLT:       alu_res = {{(W-1){1'b0}}, slt_lt};
      OP_LW, OP_SW: alu_res = a_q + alu_opb;
      OP_SHL:       alu_res = a_q << b_q[3:0];
      OP_SHR:       alu_res = a_q >> b_q[3:0];
      OP_LI:        alu_res = alu_opb;
      default:      alu_res = a_q;
    endcase
  end

  // Next-state for the holding registers; strobes are honoured in any defined state
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    a_d   = a_q;
    b_d   = b_q;
    alu_d = alu_q;
    mdr_d = mdr_q;
    rf_we = 1'b0;
    if (state_ok) begin
      if (IRWrite) ir_d = mem_rdata;
      if (PCWrite) pc_d = pc_q + W'(1);
      rf_we = RegWrite && !(R0_ZERO && f_rd == '0);
      unique case (state)
        ST_DECODE: begin
          a_d = rd_a;
          b_d = rd_b;
        end
        ST_EXEC:  alu_d = alu_res;
        ST_MEM:   mdr_d = mem_rdata;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= PC_RESET;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
      mdr_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      alu_q <= alu_d;
      mdr_q <= mdr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[f_rd] <= wb_data;
    end
  end

  // Memory interface; write enable is gated by reset so an aborted store never lands
  assign mem_addr  = (state == ST_FETCH) ? pc_q : alu_q;
  assign mem_wdata = b_q;
  assign mem_we    = MemWrite && (state == ST_MEM) && !reset;

  assign pc   = pc_q;
  assign zero = (alu_q == '0);

endmodule

// File: tb/tb_mc_datapath.sv
// Directed bench: acts as controller and unified memory for mc_datapath and checks
// architectural state after each instruction against hand-computed values.
module tb_mc_datapath;

  logic        clk;
  logic        reset;
  logic [2:0]  state;
  logic        IRWrite, PCWrite, RegWrite, MemWrite;
  logic [3:0]  ALUop;
  logic [3:0]  opcode;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc, dbg_data;
  logic        mem_we, zero;
  logic [3:0]  dbg_addr;

  logic [15:0] mem [256];
  int          n_vec;
  int          n_err;
  int          we_cnt;
  logic [15:0] we_addr, we_data;

  mc_datapath #(.PC_RESET(16'h0000), .R0_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset), .state(state),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .ALUop(ALUop), .opcode(opcode),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .pc(pc), .zero(zero), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  // Memory model: program image, then synchronous writes with a write log
  initial begin
    we_cnt  = 0;
    we_addr = '0;
    we_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0]  = 16'hA112;  // LI  R1,0x12
    mem[1]  = 16'hA234;  // LI  R2,0x34
    mem[2]  = 16'h0312;  // ADD R3,R1,R2
    mem[3]  = 16'h7305;  // SW  R3,[R0+5]
    mem[4]  = 16'h6405;  // LW  R4,[R0+5]
    mem[5]  = 16'h0000;  // data slot; after the store it executes as ADD R0,R4,R6
    mem[6]  = 16'hA100;  // LI  R1,0
    mem[7]  = 16'hA201;  // LI  R2,1
    mem[8]  = 16'h1512;  // SUB R5,R1,R2
    mem[9]  = 16'h1622;  // SUB R6,R2,R2
    mem[10] = 16'h5751;  // SLT R7,R5,R1
    mem[11] = 16'hA0FF;  // LI  R0,0xFF
    mem[12] = 16'hA913;  // LI  R9,0x13
    mem[13] = 16'h8829;  // SHL R8,R2,R9
    mem[14] = 16'h730F;  // SW  R3,[R0+15] (aborted by reset)
    mem[15] = 16'h1234;
    forever begin
      @(posedge clk);
      if (mem_we) begin
        mem[mem_addr[7:0]] = mem_wdata;
        we_cnt  = we_cnt + 1;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
    end
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, dbg_data, exp);
  endtask

  // One controller cycle: drive at negedge, return at the following negedge
  task automatic cyc(input logic [2:0] st, input logic iw, input logic pw,
                     input logic rw, input logic mw, input logic [3:0] op);
    state = st; IRWrite = iw; PCWrite = pw; RegWrite = rw; MemWrite = mw; ALUop = op;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input logic [15:0] instr, input string tag);
    logic [3:0] op;
    op = instr[15:12];
    cyc(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    chk({tag, ".opcode"}, 16'(opcode), 16'(op));
    cyc(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    cyc(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, op);
    if (op == 4'h6 || op == 4'h7) cyc(3'd3, 1'b0, 1'b0, 1'b0, op == 4'h7, 4'h0);
    cyc(3'd4, 1'b0, 1'b0, op != 4'h7, 1'b0, 4'h0);
  endtask

  initial begin
    int we0;
    n_vec = 0; n_err = 0;
    reset = 1'b1; state = 3'd0; IRWrite = 1'b0; PCWrite = 1'b0; RegWrite = 1'b0;
    MemWrite = 1'b0; ALUop = 4'h0; dbg_addr = 4'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;

    // Reset state
    chk("rst.pc", pc, 16'h0000);
    chk("rst.opcode", 16'(opcode), 16'h0000);
    chk("rst.mem_we", 16'(mem_we), 16'h0000);
    chk("rst.zero", 16'(zero), 16'h0001);
    for (int i = 0; i < 16; i++) chk_reg($sformatf("rst.R%0d", i), 4'(i), 16'h0000);
    @(negedge clk);

    // LI, LI, ADD
    run(16'hA112, "li1");
    run(16'hA234, "li2");
    run(16'h0312, "add");
    chk_reg("add.R1", 4'd1, 16'h0012);
    chk_reg("add.R2", 4'd2, 16'h0034);
    chk_reg("add.R3", 4'd3, 16'h0046);
    chk("add.pc", pc, 16'h0003);

    // Store then load back
    we0 = we_cnt;
    run(16'h7305, "sw");
    chk("sw.we_count", 16'(we_cnt - we0), 16'h0001);
    chk("sw.addr", we_addr, 16'h0005);
    chk("sw.data", we_data, 16'h0046);
    chk("sw.mem5", mem[5], 16'h0046);
    run(16'h6405, "lw");
    chk_reg("lw.R4", 4'd4, 16'h0046);
    chk("lw.pc", pc, 16'h0005);

    // Overwritten slot writes R0, which must stay zero
    run(16'h0046, "r0add");
    chk_reg("r0add.R0", 4'd0, 16'h0000);

    // SUB / zero flag / signed SLT
    run(16'hA100, "li1z");
    run(16'hA201, "li2o");
    run(16'h1512, "sub1");
    chk_reg("sub1.R5", 4'd5, 16'hFFFF);
    chk("sub1.zero", 16'(zero), 16'h0000);
    run(16'h1622, "sub2");
    chk_reg("sub2.R6", 4'd6, 16'h0000);
    chk("sub2.zero", 16'(zero), 16'h0001);
    run(16'h5751, "slt");
    chk_reg("slt.R7", 4'd7, 16'h0001);

    // R0 write drop, shift by B[3:0]
    run(16'hA0FF, "liR0");
    chk_reg("liR0.R0", 4'd0, 16'h0000);
    run(16'hA913, "li9");
    chk_reg("li9.R9", 4'd9, 16'h0013);
    run(16'h8829, "shl");
    chk_reg("shl.R8", 4'd8, 16'h0008);
    chk("shl.pc", pc, 16'h000E);

    // Reset during the memory state of a store
    we0 = we_cnt;
    cyc(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("abort.opcode", 16'(opcode), 16'h0007);
    cyc(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    cyc(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 4'h7);
    state = 3'd3; MemWrite = 1'b1;
    #1;
    chk("abort.we_before", 16'(mem_we), 16'h0001);
    chk("abort.addr", mem_addr, 16'h000F);
    chk("abort.wdata", mem_wdata, 16'h0046);
    reset = 1'b1;
    #1;
    chk("abort.we_reset", 16'(mem_we), 16'h0000);
    @(posedge clk);
    @(negedge clk);
    chk("abort.we_held", 16'(mem_we), 16'h0000);
    state = 3'd0; MemWrite = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort.we_count", 16'(we_cnt - we0), 16'h0000);
    chk("abort.mem15", mem[15], 16'h1234);
    chk("abort.pc", pc, 16'h0000);
    chk("abort.opcode_rst", 16'(opcode), 16'h0000);
    chk("abort.zero", 16'(zero), 16'h0001);
    for (int i = 0; i < 16; i++) chk_reg($sformatf("abort.R%0d", i), 4'(i), 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
